// File: rtl/conc_obs_recorder_if.sv
// Observe-strobe capture inputs and valid/ready drain port of conc_obs_recorder.
interface conc_obs_recorder_if #(
  parameter int DATA_W = 8,
  parameter int CYC_W  = 16
);
  logic                    obs;
  logic [DATA_W-1:0]       dut_out;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [CYC_W+DATA_W-1:0] rd_data;

  modport master (output obs, dut_out, rd_ready, input  rd_valid, rd_data);
  modport slave  (input  obs, dut_out, rd_ready, output rd_valid, rd_data);
endinterface

// File: rtl/conc_obs_recorder.sv
// Records {cycle, data} for every observe strobe seen in RUN into a FIFO drained by valid/ready.
// Optional feature macro CONC_OBS_DEDUP_EN: suppress captures repeating the last accepted data.
module conc_obs_recorder #(
  parameter int DATA_W       = 8,
  parameter int CYC_W        = 16,
  parameter int DEPTH        = 16,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   clear_i,
  conc_obs_recorder_if.slave     bus,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   running_o,
  output logic                   overflow_o,
  output logic [7:0]             drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = CYC_W + DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_e;
  typedef logic [AW:0]      cnt_t;
  typedef logic [CYC_W-1:0] cyc_t;

  state_e        state_q, state_d;
  cyc_t          cyc_q, cyc_d;
  cnt_t          wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [RW-1:0] head_q, head_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_q, drop_d;
  logic [RW-1:0] mem [DEPTH];

  cnt_t          level;
  logic          full, pop, dup, attempt, accept, drop;
  logic [RW-1:0] wdata;

  assign level   = wr_cnt_q - rd_cnt_q;
  assign full    = (level == cnt_t'(DEPTH));
  assign pop     = bus.rd_valid && bus.rd_ready && !clear_i;
  assign attempt = running_o && bus.obs && !clear_i && !dup;
  // A full FIFO still takes the capture when the head leaves in the same cycle.
  assign accept  = attempt && (!full || pop);
  assign drop    = attempt && !accept;
  assign wdata   = {cyc_q, bus.dut_out};

`ifdef CONC_OBS_DEDUP_EN
  logic              last_vld_q;
  logic [DATA_W-1:0] last_data_q;

  assign dup = last_vld_q && (bus.dut_out == last_data_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_vld_q  <= 1'b0;
      last_data_q <= '0;
    end else if (clear_i) begin
      last_vld_q  <= 1'b0;
    end else if (accept) begin
      last_vld_q  <= 1'b1;
      last_data_q <= bus.dut_out;
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    state_d    = state_q;
    cyc_d      = cyc_q;
    wr_cnt_d   = wr_cnt_q + cnt_t'(accept);
    rd_cnt_d   = rd_cnt_q + cnt_t'(pop);
    overflow_d = overflow_q | drop;
    drop_d     = drop_q;
    head_d     = head_q;

    if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

    case (state_q)
      S_IDLE: if (start_i) state_d = S_RUN;
      S_RUN: begin
        cyc_d = cyc_q + cyc_t'(1);
        if (stop_i || (STOP_ON_FULL && drop)) state_d = S_HALT;
      end
      S_HALT: if (start_i) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    if (clear_i) begin
      state_d    = S_IDLE;
      cyc_d      = '0;
      wr_cnt_d   = '0;
      rd_cnt_d   = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
      head_d     = '0;
    end else if (wr_cnt_d != rd_cnt_d) begin
      // Next head is the entry being written now when the FIFO would otherwise be empty.
      head_d = (accept && rd_cnt_d[AW-1:0] == wr_cnt_q[AW-1:0]) ? wdata
                                                               : mem[rd_cnt_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      head_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      head_q     <= head_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // NOTE: storage array is not reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_cnt_q[AW-1:0]] <= wdata;
  end

  assign bus.rd_valid = (level != '0);
  assign bus.rd_data  = head_q;
  assign level_o      = level;
  assign running_o    = (state_q == S_RUN);
  assign overflow_o   = overflow_q;
  assign drop_cnt_o   = drop_q;
endmodule
